// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the RAM port controller: controller state encoding
// and the default RAM geometry used by mem and its port controllers.
package mem_ctrl_pkg;

    localparam int DATA_WIDTH = 290;
    localparam int ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        TAIL  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Response FIFO for mem_port_ctrl. Synchronous, power-of-two depth, with a
// registered head so rsp_valid_o/rsp_rdata_o come straight from flops.
// Ports:
//   clk, reset_N   clock, async active-low reset
//   push_i         write push_data_i this cycle (never issued when full)
//   push_data_i    data to enqueue
//   pop_i          consumer ready; pops when the head is valid
//   count_o        current occupancy, 0..DEPTH
//   rsp_valid_o    head valid
//   rsp_rdata_o    head data
module mem_rsp_fifo #(
    parameter int DATA_WIDTH = mem_ctrl_pkg::DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset_N,
    input  logic                    push_i,
    input  logic [DATA_WIDTH-1:0]   push_data_i,
    input  logic                    pop_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] store_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d, left;
    logic [DATA_WIDTH-1:0] head_d;
    logic                  pop;

    assign pop     = pop_i && rsp_valid_o;
    assign count_o = count_q;

    // The head register must show the entry that will be at the front after
    // this edge: an older stored entry if one remains, otherwise the word
    // being pushed right now.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(pop);
        left     = count_q - CW'(pop);
        count_d  = left + CW'(push_i);
        head_d   = rsp_rdata_o;
        if (left != '0) begin
            head_d = store_q[rd_ptr_d];
        end else if (push_i) begin
            head_d = push_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_q + PW'(push_i);
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_valid_o <= (count_d != '0);
            rsp_rdata_o <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            store_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Request-side controller for one port of the single-cycle-latency RAM.
// Turns a valid/ready request stream into cs/we/oe signalling: single-beat
// writes and incrementing (wrapping) burst reads. Read data returns through
// a credit-protected response FIFO.
// Ports:
//   clk, reset_N                    clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_addr, req_len,      request: 1 = write; start address;
//   req_wdata                       read beats minus one; write data
//   rsp_valid/rsp_ready/rsp_rdata   response stream (FIFO head)
//   mem_address, mem_data_in,       RAM port drive (all registered)
//   mem_cs, mem_we, mem_oe
//   mem_data_out                    RAM read data, one cycle after a read
//
// state | meaning
// IDLE  | bus idle, accepting requests
// WRITE | one write beat on the bus, accepting requests
// READ  | burst read, one beat issued per cycle while credit allows
// TAIL  | bus held one cycle so the last read's data stays driven
module mem_port_ctrl #(
    parameter int DATA_WIDTH = mem_ctrl_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_ctrl_pkg::ADDR_WIDTH,
    parameter int LEN_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    import mem_ctrl_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic                  inflight_q;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           occupancy;
    logic                  accept;
    logic                  issue;

    assign req_ready = reset_N && (state_q == IDLE || state_q == WRITE);
    assign accept    = req_valid && req_ready;

    // A beat in flight already owns a FIFO slot. A same-cycle pop is not
    // credited back, so the FIFO can never be pushed while full.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign issue     = (state_q == READ) && (occupancy < DEPTH_C);

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_oe      <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
        end else begin
            inflight_q <= issue;
            case (state_q)
                IDLE, WRITE: begin
                    if (accept) begin
                        mem_cs      <= 1'b1;
                        mem_address <= req_addr;
                        if (req_we) begin
                            state_q     <= WRITE;
                            mem_we      <= 1'b1;
                            mem_oe      <= 1'b0;
                            mem_data_in <= req_wdata;
                        end else begin
                            state_q     <= READ;
                            mem_we      <= 1'b0;
                            mem_oe      <= 1'b1;
                            cur_addr_q  <= req_addr;
                            remaining_q <= req_len;
                        end
                    end else begin
                        state_q <= IDLE;
                        mem_cs  <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_oe  <= 1'b0;
                    end
                end
                READ: begin
                    // Without credit the bus stays up on the same address;
                    // the extra RAM read is simply not captured.
                    if (issue) begin
                        cur_addr_q <= cur_addr_q + 1'b1;
                        if (remaining_q == '0) begin
                            state_q <= TAIL;
                        end else begin
                            remaining_q <= remaining_q - 1'b1;
                            mem_address <= cur_addr_q + 1'b1;
                        end
                    end
                end
                TAIL: begin
                    state_q <= IDLE;
                    mem_cs  <= 1'b0;
                    mem_oe  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    mem_cs  <= 1'b0;
                    mem_we  <= 1'b0;
                    mem_oe  <= 1'b0;
                end
            endcase
        end
    end

    mem_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset_N     (reset_N),
        .push_i      (inflight_q),
        .push_data_i (mem_data_out),
        .pop_i       (rsp_ready),
        .count_o     (fifo_count),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata)
    );

endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Request-side controller for one port of the team's synchronous single-cycle-latency RAM (`mem`). It converts a valid/ready request stream into the RAM port's chip-select/write-enable/output-enable signalling:
- single-beat writes;
- incrementing burst reads with address wrap.

Read data is returned on a valid/ready response stream through a credit-protected response FIFO. One instance drives one RAM port; two instances cover a dual-port RAM.

## Interface
Parameters:
- DATA_WIDTH, 290, RAM word width
- ADDR_WIDTH, 8, RAM address width; bursts wrap modulo 2^ADDR_WIDTH
- LEN_WIDTH, 4, burst length field width; burst = req_len+1 beats (1..16)
- FIFO_DEPTH, 4, response FIFO entries; power of two, minimum 2

Ports:
- clk, input, 1, single clock
- reset_N, input, 1, asynchronous active-low reset
- req_valid, input, 1, request present
- req_ready, output, 1, request accepted when req_valid && req_ready
- req_we, input, 1, 1 = write, 0 = burst read
- req_addr, input, ADDR_WIDTH, start address
- req_len, input, LEN_WIDTH, read beats minus one; ignored for writes
- req_wdata, input, DATA_WIDTH, write data
- rsp_valid, output, 1, FIFO head valid
- rsp_ready, input, 1, consumer takes head
- rsp_rdata, output, DATA_WIDTH, FIFO head data
- mem_address, output, ADDR_WIDTH, to RAM address
- mem_data_in, output, DATA_WIDTH, to RAM data in
- mem_cs, output, 1, to RAM chip select
- mem_we, output, 1, to RAM write enable
- mem_oe, output, 1, to RAM output enable
- mem_data_out, input, DATA_WIDTH, from RAM data out; valid only while cs && oe && !we

## Operation
- The clock is clk. Reset is asynchronous and active-low on reset_N.
- Reset forces all of the following, immediately and mid-operation:
  - state = IDLE;
  - FIFO emptied;
  - in-flight flag cleared;
  - all registered outputs 0 (mem_cs, mem_we, mem_oe, mem_address, mem_data_in, rsp_valid, rsp_rdata).
- req_ready = 1 only in IDLE and WRITE. This is decoded combinationally from state and is therefore 0 during reset.
- FSM states:
  - IDLE: mem_cs = 0. A write accept goes to WRITE. A read accept loads cur_addr = req_addr and remaining = req_len, then goes to READ.
  - WRITE: mem_cs = 1, mem_we = 1, mem_oe = 0; address and data are those of the accepted request. A new write accept stays in WRITE, a read accept goes to READ, otherwise IDLE.
  - READ: mem_cs = 1, mem_oe = 1, mem_we = 0, mem_address = cur_addr.
    - An issue fires when fifo_count + inflight < FIFO_DEPTH.
    - On issue: cur_addr increments (255 → 0), remaining decrements.
    - Issue with remaining == 0 goes to TAIL.
    - With no credit, the bus stays asserted and the address is held. The non-issued read is harmless and is not captured.
  - TAIL: one cycle. cs/oe are held with we = 0 so that the last read's data remains driven. Then IDLE.
- Capture: inflight <= issue. When inflight = 1, mem_data_out is pushed into the FIFO that cycle.
- Credit accounting ignores a same-cycle pop (conservative). The FIFO never overflows, so a push on a full FIFO is impossible by construction.
- FIFO: simultaneous push and pop is allowed at any occupancy, and count is unchanged. A pop with rsp_valid = 0 does nothing.
- Response order equals issue order, which is ascending (wrapping) address.

## Timing
- Request accepted at edge E0. Mem signals for that request are registered and asserted during cycle E0..E1.
- Write: RAM stores at E1. A read of the same address accepted at or after E1 returns the new data.
- Read beat issued in cycle C:
  - RAM registers the data at the end of C;
  - mem_data_out is valid during C+1 and is captured at the end of C+1;
  - rsp_valid is asserted in C+2.
- Accept-to-first-response latency is 3 cycles.
- Burst throughput is 1 beat per cycle while credit allows. Back-to-back writes run at 1 per cycle.
- After TAIL, IDLE is reached with req_ready = 1. Minimum read-request spacing is len+3 cycles.

## Structure
- Package mem_ctrl_pkg holds:
  - the state enum typedef (IDLE, WRITE, READ, TAIL);
  - default width localparams shared with `mem` (DATA_WIDTH, ADDR_WIDTH).
- Sub-module mem_rsp_fifo holds the parameterised synchronous FIFO (push, pop, count, registered head), with the same clock and reset.
- The FSM, address/length counters and inflight flag live in mem_port_ctrl.

## Test plan
- Write 0xA5 to addr 3, then read len = 0 at addr 3: one write cycle (cs = 1, we = 1), then rsp_rdata = 0xA5 with rsp_valid exactly 3 cycles after read accept.
- Preload addrs 254, 255, 0, 1 with 1..4, then read len = 3 at addr 254: mem_address sequence 254, 255, 0, 1; responses 1, 2, 3, 4 in order, then TAIL, then IDLE.
- rsp_ready = 0 during an 8-beat burst: issuing stops after 4 entries (FIFO full), bus held, no push lost. Releasing rsp_ready yields all 8 words in order.
- Writes to addrs 10, 11, 12 on consecutive cycles: req_ready stays 1, three consecutive WRITE cycles; readback returns the correct data.
- req_valid asserted during READ: req_ready = 0, request held, accepted in the cycle after TAIL.
- reset_N dropped mid-burst: all outputs are 0 in the same cycle and rsp_valid = 0. After release, a new read len = 0 completes normally.
